// File: rtl/sample_capture_pkg.sv
// ----------------------------------------------------------------------------
// sample_capture_pkg
//   Shared types and constants for the audio sample capture buffer.
//
//   capture_state_e : capture FSM states (IDLE, CAPTURE, DONE)
//   AUDIO_DATA_W    : default audio sample width in bits
//   CAPTURE_DEPTH   : default capture buffer depth in samples (power of two)
// ----------------------------------------------------------------------------
package sample_capture_pkg;

    localparam int AUDIO_DATA_W  = 16;
    localparam int CAPTURE_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } capture_state_e;

endpackage

// File: rtl/capture_ram.sv
// ----------------------------------------------------------------------------
// capture_ram
//   Simple dual-port sample memory: one write port, one synchronous read
//   port. A read and a write to the same address in the same cycle return
//   the old contents. No reset on the array or the read register, so the
//   array maps onto block RAM.
//
//   Ports
//     clk      in   clock
//     wr_en    in   write strobe
//     wr_addr  in   write address
//     wr_data  in   write data
//     rd_en    in   read strobe; read register holds while low
//     rd_addr  in   read address
//     rd_data  out  registered read data, valid the cycle after rd_en
// ----------------------------------------------------------------------------
module capture_ram
    import sample_capture_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W,
    parameter int DEPTH  = CAPTURE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of mem sees the pre-write value on a same-address
    // collision, giving read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_capture_buffer.sv
// ----------------------------------------------------------------------------
// sample_capture_buffer
//   Records a burst of NUM_SAMPLES audio samples, one per rising edge of the
//   I2S frame clock lrclk, into an on-chip buffer, then stops. The buffer is
//   read back through a one-cycle-latency synchronous read port that works
//   in any state.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | reset state, no capture armed; start_i arms a new burst
//   CAPTURE | writing one sample per lrclk rising edge; abort_i cancels
//   DONE    | burst of NUM_SAMPLES complete; start_i arms a new burst
//
//   Ports
//     clk         in   system clock
//     rst_ni      in   asynchronous active-low reset
//     lrclk       in   frame clock, synchronous to clk
//     sample_i    in   sample word captured on lrclk rising edge
//     start_i     in   pulse: arm a new capture (IDLE/DONE only)
//     abort_i     in   pulse: cancel a running capture (CAPTURE only)
//     busy_o      out  high in CAPTURE
//     done_o      out  high in DONE
//     count_o     out  samples written in the current or last burst
//     rd_en_i     in   read request
//     rd_addr_i   in   read address
//     rd_data_o   out  read data, registered
//     rd_valid_o  out  read data valid, one cycle after rd_en_i
// ----------------------------------------------------------------------------
module sample_capture_buffer
    import sample_capture_pkg::*;
#(
    parameter int DATA_W      = AUDIO_DATA_W,
    parameter int DEPTH       = CAPTURE_DEPTH,
    parameter int NUM_SAMPLES = 501,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              lrclk,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(NUM_SAMPLES - 1);
    localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W+1)'(1);

    capture_state_e    state;
    capture_state_e    state_next;

    logic              lrclk_q;
    logic              lr_edge;
    logic              wr_en;
    logic              clear_count;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              rd_valid;
    logic              rd_loaded;

    assign lr_edge = lrclk & ~lrclk_q;

    // Bursts always start at address 0 and write consecutively, so the write
    // pointer is the low bits of the sample count. When NUM_SAMPLES equals
    // DEPTH the pointer wraps to 0 on the final write, which is harmless
    // because the FSM leaves CAPTURE on that same write.
    assign wr_ptr = count[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        wr_en       = 1'b0;
        clear_count = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next  = CAPTURE;
                    clear_count = 1'b1;
                end
            end
            CAPTURE: begin
                // abort wins over a coincident frame edge: no write
                if (abort_i) begin
                    state_next = IDLE;
                end else if (lr_edge) begin
                    wr_en = 1'b1;
                    if (count == LAST_COUNT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (start_i) begin
                    state_next  = CAPTURE;
                    clear_count = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Edge detector, sample counter, read-valid tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            lrclk_q <= 1'b0;
        end else begin
            lrclk_q <= lrclk;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clear_count) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + COUNT_ONE;
        end
    end

    // The RAM read register has no reset. rd_loaded masks it to zero until
    // the first read after reset has landed, so rd_data_o resets to 0
    // without putting a reset on the block RAM output.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid  <= 1'b0;
            rd_loaded <= 1'b0;
        end else begin
            rd_valid <= rd_en_i;
            if (rd_en_i) begin
                rd_loaded <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample memory
    // ------------------------------------------------------------------
    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (sample_i),
        .rd_en   (rd_en_i),
        .rd_addr (rd_addr_i),
        .rd_data (ram_rd_data)
    );

    assign busy_o     = (state == CAPTURE);
    assign done_o     = (state == DONE);
    assign count_o    = count;
    assign rd_valid_o = rd_valid;
    assign rd_data_o  = rd_loaded ? ram_rd_data : '0;

endmodule

// File: doc/sample_capture_buffer.md
# sample_capture_buffer

Audio sample sink that records a fixed-length burst of 16-bit samples, one per rising edge of the I2S frame clock `lrclk`, into an on-chip buffer, then stops. It sits on the receive side of the audio path, downstream of the FIR filter or a test-tone source. It lets software or the testbench read back a captured burst, for example one full sine test sequence, through a simple synchronous read port.

## Interface
- `DATA_W`, 16: sample width in bits.
- `DEPTH`, 1024: buffer depth in samples; must be a power of two.
- `NUM_SAMPLES`, 501: samples per capture burst; legal range 1..`DEPTH`.
- `ADDR_W`, `$clog2(DEPTH)`: derived; do not override.
- `clk` in 1: system clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `lrclk` in 1: frame clock, synchronous to `clk`, each level held at least 2 `clk` cycles.
- `sample_i` in `DATA_W`: sample word, stable around every `lrclk` rising edge.
- `start_i` in 1: single-cycle pulse that arms a new capture.
- `abort_i` in 1: single-cycle pulse that cancels a running capture.
- `busy_o` out 1: high while in CAPTURE.
- `done_o` out 1: high in DONE, i.e. the burst is complete.
- `count_o` out `ADDR_W+1`: number of samples written in the current or last burst.
- `rd_en_i` in 1: read request.
- `rd_addr_i` in `ADDR_W`: read address.
- `rd_data_o` out `DATA_W`: read data.
- `rd_valid_o` out 1: read data valid, one cycle after `rd_en_i`.

## Operation
- Edge detect: register `lrclk_q`, reset value 0. `edge = lrclk & ~lrclk_q`. The edge is acted on only in CAPTURE.
- FSM states: IDLE (reset state), CAPTURE, DONE.
- IDLE, on `start_i`: go to CAPTURE and clear the write pointer and `count_o`.
- CAPTURE, on `edge`: write `mem[wr_ptr] <= sample_i`, increment `wr_ptr` and `count_o`. The write that makes `count_o == NUM_SAMPLES` also moves the FSM to DONE.
- CAPTURE, on `abort_i`: go to IDLE and keep `count_o`. `abort_i` beats a coincident `edge`: that sample is not written. `start_i` is ignored in CAPTURE.
- DONE, on `start_i`: go to CAPTURE with pointer and count cleared. Old data is overwritten progressively. `abort_i` is ignored in IDLE and DONE.
- No writes happen outside CAPTURE. `lrclk` held high produces exactly one write.
- Read port:
  - Accepted in any state; no backpressure.
  - `rd_data_o` is registered and holds its value while `rd_en_i` is low.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
  - Addresses at or above `count_o` return stale or uninitialised contents.
- The buffer memory is never reset or cleared.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `count_o`=0, `rd_data_o`=0, `rd_valid_o`=0, state IDLE.
- `start_i` sampled at edge t: `busy_o`=1 from t+1. The earliest accepted `lrclk` edge is one seen at t+1.
- `count_o` updates the cycle after the write.
- `done_o`=1 and `busy_o`=0 the cycle after the final write.
- `abort_i` sampled at edge t: `busy_o`=0 at t+1.
- Read latency is exactly 1 cycle: `rd_en_i` at t gives `rd_valid_o`=1 and data at t+1. Back-to-back reads give one result per cycle.
- Reset asserted mid-capture: return to IDLE immediately, `count_o`=0, no further writes, buffer contents undefined.

## Structure
- Package `sample_capture_pkg`: `capture_state_e` (IDLE, CAPTURE, DONE) and constants `AUDIO_DATA_W`=16 and `CAPTURE_DEPTH`=1024.
- Sub-module `capture_ram`: simple dual-port RAM, one write port and one synchronous read port, read-before-write, no reset, written for BRAM inference.
- The top level holds the edge detector, FSM, counters and read-valid register.

## Test plan
- Reset release with `lrclk` toggling and no `start_i` -> all outputs 0, no writes (readback of addr 0 unchanged from preload).
- `NUM_SAMPLES`=8, `start_i`, then `lrclk` period 16 cycles with `sample_i`=16'h1000+n -> `done_o` the cycle after the 8th write, `count_o`=8. Reads of addr 0..7 return 16'h1000..16'h1007. A 9th edge leaves addr 8 at its preload value.
- Abort after 3 writes, with `abort_i` in the same cycle as the 4th edge -> `busy_o`=0 and `done_o`=0 next cycle, `count_o`=3, addr 3 unchanged.
- From DONE, `start_i` then 8 samples 16'hA000+n -> `count_o` restarts at 0, then reaches 8. Readback gives 16'hA000..16'hA007.
- In CAPTURE, read addr k in the same cycle that addr k is written -> `rd_data_o`=old value at the next cycle, and a re-read returns the new value. Back-to-back reads each return `rd_valid_o`=1 at 1-cycle latency.
- `rst_ni` pulsed low after 4 of 8 writes -> `busy_o`, `done_o` and `count_o` are 0 asynchronously. Later `lrclk` edges cause no writes until the next `start_i`.
